axi4_lite_write_master: RTL and testbench

- AXI4-Lite write-channel initiator. Converts a single-beat store request from the core's load/store unit into AW, W and B channel transactions.
- Sits between the RV32IM core's data-memory port and the interconnect or in-house write slave.
- One outstanding write at a time. The request side is stalled (req_ready low) until the B response completes.

---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/axi4_lite_write_master.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_write_master.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite master types and response codes
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT_B = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_write_master.sv
// rtl/axi4_lite_write_master.sv - single-outstanding AXI4-Lite write initiator
module axi4_lite_write_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter bit HOLD_AW_UNTIL_W = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY
);
  import axi4_lite_pkg::*;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state_q, state_n;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
  logic                    awvalid_q, awvalid_n;
  logic                    wvalid_q, wvalid_n;
  logic                    bready_q, bready_n;
  logic                    aw_done_q, aw_done_n;
  logic                    w_done_q, w_done_n;
  logic                    wr_done_q, wr_done_n;
  logic                    wr_err_q, wr_err_n;
  logic                    req_ready_q, req_ready_n;
  logic                    aw_hs, w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      awaddr_q    <= awaddr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      aw_done_q   <= aw_done_n;
      w_done_q    <= w_done_n;
      wr_done_q   <= wr_done_n;
      wr_err_q    <= wr_err_n;
      req_ready_q <= req_ready_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    awaddr_n  = awaddr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    wr_done_n = 1'b0;
    wr_err_n  = 1'b0;
    // A held AWVALID after its handshake must not count as a second address beat.
    aw_hs     = awvalid_q && M_AXI_AWREADY && !aw_done_q;
    w_hs      = wvalid_q && M_AXI_WREADY;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          awaddr_n  = req_addr;
          wdata_n   = req_data;
          wstrb_n   = req_strb;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          state_n   = ST_SEND;
        end
      end
      ST_SEND: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          awvalid_n = 1'b0;
          wvalid_n  = 1'b0;
          bready_n  = 1'b1;
          state_n   = ST_WAIT_B;
        end else begin
          if (aw_hs) begin
            aw_done_n = 1'b1;
            if (!HOLD_AW_UNTIL_W) begin
              awvalid_n = 1'b0;
            end
          end
          if (w_hs) begin
            w_done_n = 1'b1;
            wvalid_n = 1'b0;
          end
        end
      end
      ST_WAIT_B: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_n  = 1'b0;
          wr_done_n = 1'b1;
          wr_err_n  = (M_AXI_BRESP != RESP_OKAY);
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    req_ready_n = (state_n == ST_IDLE);
  end

  assign req_ready     = req_ready_q;
  assign wr_done       = wr_done_q;
  assign wr_err        = wr_err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// tb/tb_axi4_lite_write_master.sv - scoreboard bench for the AXI4-Lite write master
module tb_axi4_lite_write_master;

  typedef struct {
    logic err;
    int   cyc;
  } b_exp_t;

  logic        clk, rst;
  logic        req_valid;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb;
  logic        awready, wready, bvalid;
  logic [1:0]  bresp;

  logic        s_req_ready, s_wr_done, s_wr_err, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        h_req_ready, h_wr_done, h_wr_err, h_awvalid, h_wvalid, h_bready;
  logic [31:0] h_awaddr, h_wdata;
  logic [3:0]  h_wstrb;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ph = 0, bph = 0;
  int aw_delay = 0, w_delay = 0, b_delay = 0;
  logic       bv_force = 1'b0;
  logic [1:0] bresp_v = 2'b00;
  logic [31:0] mem [0:15];

  logic [31:0] qaw[$];
  logic [35:0] qw_s[$], qw_h[$];
  b_exp_t      qb_s[$], qb_h[$];
  logic [31:0] m_a;
  logic [35:0] m_w;
  b_exp_t      m_b;

  axi4_lite_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HOLD_AW_UNTIL_W(1'b0)) dut_s (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .wr_done(s_wr_done), .wr_err(s_wr_err),
    .M_AXI_AWADDR(s_awaddr), .M_AXI_AWVALID(s_awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(s_wdata), .M_AXI_WSTRB(s_wstrb), .M_AXI_WVALID(s_wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(s_bready)
  );

  axi4_lite_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HOLD_AW_UNTIL_W(1'b1)) dut_h (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(h_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .wr_done(h_wr_done), .wr_err(h_wr_err),
    .M_AXI_AWADDR(h_awaddr), .M_AXI_AWVALID(h_awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(h_wdata), .M_AXI_WSTRB(h_wstrb), .M_AXI_WVALID(h_wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(h_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= (s_awvalid || s_wvalid) ? ph + 1 : 0;
    bph <= s_bready ? bph + 1 : 0;
  end

  // Slave readiness is scheduled by cycles elapsed since the request entered SEND/WAIT_B.
  assign awready = (ph >= aw_delay);
  assign wready  = (ph >= w_delay);
  assign bvalid  = (s_bready && (bph >= b_delay)) || bv_force;
  assign bresp   = bresp_v;

  // In-house slave: latches the held address together with the data beat.
  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 32'h1122_3344;
    end else if (h_wvalid && wready && h_awvalid) begin
      for (int b = 0; b < 4; b++)
        if (h_wstrb[b]) mem[h_awaddr[5:2]][8*b +: 8] <= h_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_awvalid && awready) begin
        chk("aw_s_pending", qaw.size() != 0, 1);
        if (qaw.size() != 0) begin
          m_a = qaw.pop_front();
          chk("awaddr_s", s_awaddr, m_a);
        end
      end
      if (s_wvalid && wready) begin
        chk("w_s_pending", qw_s.size() != 0, 1);
        if (qw_s.size() != 0) begin
          m_w = qw_s.pop_front();
          chk("w_s", {s_wstrb, s_wdata}, m_w);
        end
      end
      if (h_wvalid && wready) begin
        chk("w_h_pending", qw_h.size() != 0, 1);
        if (qw_h.size() != 0) begin
          m_w = qw_h.pop_front();
          chk("w_h", {h_wstrb, h_wdata}, m_w);
        end
      end
      if (s_wr_done) begin
        chk("done_s_pending", qb_s.size() != 0, 1);
        if (qb_s.size() != 0) begin
          m_b = qb_s.pop_front();
          chk("wr_err_s", s_wr_err, m_b.err);
          chk("done_cyc_s", cyc, m_b.cyc);
        end
      end
      if (h_wr_done) begin
        chk("done_h_pending", qb_h.size() != 0, 1);
        if (qb_h.size() != 0) begin
          m_b = qb_h.pop_front();
          chk("wr_err_h", h_wr_err, m_b.err);
          chk("done_cyc_h", cyc, m_b.cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!s_req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!s_req_ready) chk("req_ready_timeout", s_req_ready, 1);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic err, input int done_cyc);
    qaw.push_back(a);
    qw_s.push_back({s, d});
    qw_h.push_back({s, d});
    qb_s.push_back('{err: err, cyc: done_cyc});
    qb_h.push_back('{err: err, cyc: done_cyc});
  endtask

  // Called at a negedge; returns at the negedge of T+1 with the acceptance cycle T.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic err, input int lat, output int t);
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    req_valid = 1'b1;
    wait_ready();
    t = cyc;
    push_exp(a, d, s, err, t + lat);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qb_s.size() != 0 || qb_h.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", qb_s.size() + qb_h.size(), 0);
    @(negedge clk);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t, t1, t2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    @(negedge clk);
    chk("rst_req_ready", s_req_ready, 0);
    chk("rst_valids", {s_awvalid, s_wvalid, s_bready, s_wr_done}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", s_req_ready, 1);

    // Always-ready slave, minimum latency
    send(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 3, t);
    chk("t1_awvalid", {s_awvalid, s_wvalid}, 2'b11);
    to_cyc(t + 2); chk("t1_bready", s_bready, 1);
    to_cyc(t + 3); chk("t1_done", {s_wr_done, s_req_ready}, 2'b11);
    drain();

    // AWREADY late by 3 cycles, strict AXI instance drops WVALID early
    aw_delay = 3;
    send(32'h0000_0440, 32'h0BAD_F00D, 4'hC, 1'b0, 6, t);
    for (int k = 2; k <= 4; k++) begin
      to_cyc(t + k);
      chk("t2_wvalid_low", s_wvalid, 0);
      chk("t2_aw_held", {s_awvalid, s_awaddr}, {1'b1, 32'h0000_0440});
    end
    to_cyc(t + 5); chk("t2_aw_drop", {s_awvalid, s_bready}, 2'b01);
    drain();
    aw_delay = 0;

    // WREADY late by 2 cycles, HOLD instance keeps AW up until W completes
    w_delay = 2;
    send(32'h0000_2008, 32'hCAFE_5678, 4'b0011, 1'b0, 5, t);
    chk("t3_h_aw_t1", h_awvalid, 1);
    to_cyc(t + 2); chk("t3_aw_t2", {h_awvalid, s_awvalid}, 2'b10);
    to_cyc(t + 3); chk("t3_h_aw_t3", {h_awvalid, h_wvalid}, 2'b11);
    to_cyc(t + 4); chk("t3_h_aw_t4", {h_awvalid, h_bready}, 2'b01);
    drain();
    chk("t3_mem", mem[2], 32'h1122_5678);
    w_delay = 0;

    // SLVERR after a 4-cycle B delay
    b_delay = 4; bresp_v = 2'b10;
    send(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 7, t);
    for (int k = 2; k <= 6; k++) begin
      to_cyc(t + k);
      chk("t4_bready_held", s_bready, 1);
    end
    to_cyc(t + 7); chk("t4_done", {s_wr_done, s_wr_err, s_bready}, 3'b110);
    to_cyc(t + 8); chk("t4_done_pulse", s_wr_done, 0);
    drain();
    b_delay = 0; bresp_v = 2'b00;

    // Reset while waiting for B drops the write silently
    b_delay = 20;
    req_addr = 32'h0000_0020; req_data = 32'hAAAA_5555; req_strb = 4'hF; req_valid = 1'b1;
    wait_ready();
    t = cyc;
    qaw.push_back(req_addr);
    qw_s.push_back({req_strb, req_data});
    qw_h.push_back({req_strb, req_data});
    @(negedge clk); req_valid = 1'b0;
    to_cyc(t + 3);
    chk("t5_in_wait_b", s_bready, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs", {s_awvalid, s_wvalid, s_bready, h_bready, s_wr_done}, 5'b00000);
    @(negedge clk); rst = 1'b0;
    b_delay = 0;
    repeat (3) @(negedge clk);
    send(32'h0000_0024, 32'h0F0F_0F0F, 4'h5, 1'b0, 3, t);
    drain();

    // Back-to-back with req_valid held
    req_addr = 32'h0000_0100; req_data = 32'h1111_1111; req_strb = 4'hF; req_valid = 1'b1;
    wait_ready();
    t1 = cyc;
    push_exp(req_addr, req_data, req_strb, 1'b0, t1 + 3);
    @(negedge clk);
    req_addr = 32'h0000_0104; req_data = 32'h2222_2222; req_strb = 4'h3;
    wait_ready();
    t2 = cyc;
    chk("t6_b2b_gap", t2 - t1, 3);
    chk("t6_no_overlap", {s_awvalid, s_wr_done}, 2'b01);
    push_exp(req_addr, req_data, req_strb, 1'b0, t2 + 3);
    @(negedge clk); req_valid = 1'b0;
    drain();

    // Stray BVALID while idle
    bv_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t7_stray_b", {s_bready, s_wr_done, h_wr_done}, 3'b000);
    end
    bv_force = 1'b0;
    repeat (3) @(negedge clk);

    chk("queues_empty", qaw.size() + qw_s.size() + qw_h.size() + qb_s.size() + qb_h.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
